// File: rtl/load_store_unit.sv
// Load/store sequencer in front of the byte-serial memory controller.
// Accepts one decoded load/store at a time, forms the effective address, checks funct3 (and
// optionally alignment), fires a single start pulse, then waits for done or a timeout and
// returns load data to writeback or a store-completion / error strobe.
// Optional feature macro: MISALIGN_TRAP_EN (trap misaligned halfword/word accesses with
// error code 10 instead of sending them to the controller).
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 15,
    parameter int unsigned TIMEOUT_W      = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    // Request from decode/execute
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_is_store_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_base_i,
    input  logic [11:0] req_imm_i,
    input  logic [31:0] req_store_data_i,
    input  logic [4:0]  req_rd_i,
    // Memory controller
    output logic        mem_start_o,
    output logic [31:0] mem_address_o,
    output logic [2:0]  mem_mode_o,
    output logic        mem_write_enable_o,
    output logic [31:0] mem_write_data_o,
    input  logic        mem_done_i,
    input  logic [31:0] mem_read_data_i,
    input  logic        mem_active_i,
    // Writeback / completion / error
    output logic        wb_valid_o,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_data_o,
    output logic        store_done_o,
    output logic        err_valid_o,
    output logic [1:0]  err_code_o,
    output logic [31:0] err_addr_o
);

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StIssue,
        StWait,
        StResp,
        StErr
    } state_e;

    localparam logic [1:0] ErrIllegal  = 2'b01;
    localparam logic [1:0] ErrMisalign = 2'b10;
    localparam logic [1:0] ErrTimeout  = 2'b11;

    // Counter runs one bit wider so the increment never wraps before the compare.
    localparam logic [TIMEOUT_W:0] TimeoutLimit = (TIMEOUT_W + 1)'(TIMEOUT_CYCLES);

    state_e state_q;

    // Request fields latched on accept
    logic        is_store_q;
    logic [2:0]  funct3_q;
    logic [31:0] store_data_q;
    logic [4:0]  rd_q;
    logic [31:0] ea_q;

    logic [TIMEOUT_W-1:0] cnt_q;

    // Registered outputs
    logic        req_ready_q;
    logic        mem_start_q;
    logic [31:0] mem_address_q;
    logic [2:0]  mem_mode_q;
    logic        mem_write_enable_q;
    logic [31:0] mem_write_data_q;
    logic        wb_valid_q;
    logic [4:0]  wb_rd_q;
    logic [31:0] wb_data_q;
    logic        store_done_q;
    logic        err_valid_q;
    logic [1:0]  err_code_q;
    logic [31:0] err_addr_q;

    logic [31:0]        ea;
    logic               funct3_ok;
    logic               misaligned;
    logic [TIMEOUT_W:0] cnt_inc;
    logic               timeout_hit;

    // Effective address: base plus sign-extended 12-bit immediate, wrapping mod 2^32.
    assign ea = req_base_i + {{20{req_imm_i[11]}}, req_imm_i};

    // Legal funct3 encodings: loads B/H/W/BU/HU, stores B/H/W only.
    always_comb begin
        funct3_ok = 1'b0;
        case (funct3_q)
            3'b000, 3'b001, 3'b010: funct3_ok = 1'b1;
            3'b100, 3'b101:         funct3_ok = !is_store_q;
            default:                funct3_ok = 1'b0;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    // Halfword needs ea[0]==0, word needs ea[1:0]==0; bytes are always aligned.
    always_comb begin
        misaligned = 1'b0;
        case (funct3_q[1:0])
            2'b01:   misaligned = ea_q[0];
            2'b10:   misaligned = |ea_q[1:0];
            default: misaligned = 1'b0;
        endcase
    end
`else
    // The controller handles unaligned accesses byte-serially.
    assign misaligned = 1'b0;
`endif

    // The counter holds the number of cycles elapsed since the start pulse; the timeout fires
    // on the edge where that count reaches TIMEOUT_CYCLES, so the error strobe lands exactly
    // TIMEOUT_CYCLES cycles after mem_start.
    assign cnt_inc     = {1'b0, cnt_q} + {{TIMEOUT_W{1'b0}}, 1'b1};
    assign timeout_hit = (cnt_inc >= TimeoutLimit);

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q            <= StIdle;
            is_store_q         <= 1'b0;
            funct3_q           <= 3'b000;
            store_data_q       <= 32'h0;
            rd_q               <= 5'd0;
            ea_q               <= 32'h0;
            cnt_q              <= '0;
            req_ready_q        <= 1'b0;
            mem_start_q        <= 1'b0;
            mem_address_q      <= 32'h0;
            mem_mode_q         <= 3'b000;
            mem_write_enable_q <= 1'b0;
            mem_write_data_q   <= 32'h0;
            wb_valid_q         <= 1'b0;
            wb_rd_q            <= 5'd0;
            wb_data_q          <= 32'h0;
            store_done_q       <= 1'b0;
            err_valid_q        <= 1'b0;
            err_code_q         <= 2'b00;
            err_addr_q         <= 32'h0;
        end else begin
            // Strobes are single-cycle unless a branch below raises them.
            mem_start_q  <= 1'b0;
            wb_valid_q   <= 1'b0;
            store_done_q <= 1'b0;
            err_valid_q  <= 1'b0;

            case (state_q)
                StIdle: begin
                    if (req_valid_i && req_ready_q) begin
                        is_store_q   <= req_is_store_i;
                        funct3_q     <= req_funct3_i;
                        store_data_q <= req_store_data_i;
                        rd_q         <= req_rd_i;
                        ea_q         <= ea;
                        req_ready_q  <= 1'b0;
                        state_q      <= StCheck;
                    end else begin
                        // Controller has no reset: wait for it to go idle before accepting.
                        req_ready_q <= !mem_active_i;
                    end
                end

                StCheck: begin
                    if (!funct3_ok) begin
                        err_valid_q <= 1'b1;
                        err_code_q  <= ErrIllegal;
                        err_addr_q  <= ea_q;
                        state_q     <= StErr;
                    end else if (misaligned) begin
                        err_valid_q <= 1'b1;
                        err_code_q  <= ErrMisalign;
                        err_addr_q  <= ea_q;
                        state_q     <= StErr;
                    end else begin
                        // Controller-facing fields are loaded here and held through RESP.
                        mem_address_q      <= ea_q;
                        mem_mode_q         <= funct3_q;
                        mem_write_enable_q <= is_store_q;
                        mem_write_data_q   <= store_data_q;
                        mem_start_q        <= 1'b1;
                        cnt_q              <= '0;
                        state_q            <= StIssue;
                    end
                end

                StIssue: begin
                    cnt_q   <= cnt_inc[TIMEOUT_W-1:0];
                    state_q <= StWait;
                end

                StWait: begin
                    if (mem_done_i) begin
                        if (is_store_q) begin
                            store_done_q <= 1'b1;
                        end else begin
                            // x0 is hardwired to zero, so no writeback for rd==0.
                            wb_valid_q <= (rd_q != 5'd0);
                            wb_rd_q    <= rd_q;
                            wb_data_q  <= mem_read_data_i;
                        end
                        state_q <= StResp;
                    end else if (timeout_hit) begin
                        err_valid_q <= 1'b1;
                        err_code_q  <= ErrTimeout;
                        err_addr_q  <= ea_q;
                        state_q     <= StErr;
                    end else begin
                        cnt_q <= cnt_inc[TIMEOUT_W-1:0];
                    end
                end

                StResp, StErr: begin
                    req_ready_q <= !mem_active_i;
                    state_q     <= StIdle;
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign req_ready_o        = req_ready_q;
    assign mem_start_o        = mem_start_q;
    assign mem_address_o      = mem_address_q;
    assign mem_mode_o         = mem_mode_q;
    assign mem_write_enable_o = mem_write_enable_q;
    assign mem_write_data_o   = mem_write_data_q;
    assign wb_valid_o         = wb_valid_q;
    assign wb_rd_o            = wb_rd_q;
    assign wb_data_o          = wb_data_q;
    assign store_done_o       = store_done_q;
    assign err_valid_o        = err_valid_q;
    assign err_code_o         = err_code_q;
    assign err_addr_o         = err_addr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a byte-array memory controller model.
module tb_load_store_unit;

    localparam int unsigned T = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_is_store = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_base = 32'h0;
    logic [11:0] req_imm = 12'h0;
    logic [31:0] req_store_data = 32'h0;
    logic [4:0]  req_rd = 5'd0;
    logic        mem_start;
    logic [31:0] mem_address;
    logic [2:0]  mem_mode;
    logic        mem_write_enable;
    logic [31:0] mem_write_data;
    logic        mem_done;
    logic [31:0] mem_read_data;
    logic        mem_active;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        store_done;
    logic        err_valid;
    logic [1:0]  err_code;
    logic [31:0] err_addr;

    // Kind: 0 load writeback, 1 store done, 2 error, 3 load to x0 (no strobe)
    typedef struct {
        int          kind;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [1:0]  code;
        logic [31:0] addr;
        logic [2:0]  mode;
        logic        we;
        logic [31:0] wdata;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    int n_checks = 0;
    int n_errors = 0;
    int n_wb = 0, n_store = 0, n_err = 0, n_start = 0, n_done = 0;

    // Controller model state (owned by the model block) and driver-owned controls
    logic [7:0]  mem [0:4095];
    logic        mem_init_done = 1'b0;
    logic        busy_m = 1'b0, done_m = 1'b0, hang_busy_m = 1'b0;
    logic [31:0] rdata_m = 32'h0;
    int          lat_m = 0;
    logic [31:0] a_m = 32'h0, wd_m = 32'h0;
    logic [2:0]  md_m = 3'b000;
    logic        we_m = 1'b0;
    logic        hang = 1'b0, hang_release = 1'b0, stray_done = 1'b0;

    assign mem_active    = busy_m | hang_busy_m;
    assign mem_done      = done_m | stray_done;
    assign mem_read_data = rdata_m;

    always #5 clk = ~clk;

    load_store_unit #(
        .TIMEOUT_CYCLES(T),
        .TIMEOUT_W     (4)
    ) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .req_valid_i       (req_valid),
        .req_ready_o       (req_ready),
        .req_is_store_i    (req_is_store),
        .req_funct3_i      (req_funct3),
        .req_base_i        (req_base),
        .req_imm_i         (req_imm),
        .req_store_data_i  (req_store_data),
        .req_rd_i          (req_rd),
        .mem_start_o       (mem_start),
        .mem_address_o     (mem_address),
        .mem_mode_o        (mem_mode),
        .mem_write_enable_o(mem_write_enable),
        .mem_write_data_o  (mem_write_data),
        .mem_done_i        (mem_done),
        .mem_read_data_i   (mem_read_data),
        .mem_active_i      (mem_active),
        .wb_valid_o        (wb_valid),
        .wb_rd_o           (wb_rd),
        .wb_data_o         (wb_data),
        .store_done_o      (store_done),
        .err_valid_o       (err_valid),
        .err_code_o        (err_code),
        .err_addr_o        (err_addr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Monitor first (sees last cycle's model outputs), then the controller model.
    always @(negedge clk) begin
        int strobes;
        int a;
        if (rst_n) begin
            strobes = 32'(wb_valid) + 32'(store_done) + 32'(err_valid);
            if (strobes != 0) begin
                check("strobe_onehot", 32'(strobes), 32'd1);
                if (q.size() == 0) begin
                    check("sb_unexpected_strobe", 32'd1, 32'd0);
                end else begin
                    mon_e = q.pop_front();
                    if (wb_valid) begin
                        check("wb_kind", 32'(mon_e.kind), 32'd0);
                        check("wb_rd", 32'(wb_rd), 32'(mon_e.rd));
                        check("wb_data", wb_data, mon_e.data);
                        check("done_to_wb_lat", 32'(mem_done), 32'd1);
                        check("wb_addr_held", mem_address, mon_e.addr);
                    end
                    if (store_done) begin
                        check("store_kind", 32'(mon_e.kind), 32'd1);
                        check("done_to_store_lat", 32'(mem_done), 32'd1);
                        check("store_addr_held", mem_address, mon_e.addr);
                        check("store_we_held", 32'(mem_write_enable), 32'd1);
                    end
                    if (err_valid) begin
                        check("err_kind", 32'(mon_e.kind), 32'd2);
                        check("err_code", 32'(err_code), 32'(mon_e.code));
                        check("err_addr", err_addr, mon_e.addr);
                    end
                end
                n_wb    += 32'(wb_valid);
                n_store += 32'(store_done);
                n_err   += 32'(err_valid);
            end
            if (mem_start) begin
                n_start++;
                if (q.size() > 0) begin
                    check("start_addr", mem_address, q[0].addr);
                    check("start_mode", 32'(mem_mode), 32'(q[0].mode));
                    check("start_we", 32'(mem_write_enable), 32'(q[0].we));
                    check("start_wdata", mem_write_data, q[0].wdata);
                    if (q[0].kind == 2 && q[0].code != 2'b11) check("start_on_err", 32'd1, 32'd0);
                end
            end
        end

        if (!mem_init_done) begin
            for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
            mem[12'h104] = 8'h78; mem[12'h105] = 8'h56;
            mem[12'h106] = 8'h34; mem[12'h107] = 8'h12;
            mem[12'h020] = 8'h80;
            mem[12'h030] = 8'h00; mem[12'h031] = 8'h90;
            mem[12'h100] = 8'h11; mem[12'h101] = 8'h22;
            mem[12'h102] = 8'h33; mem[12'h103] = 8'h44;
            mem_init_done = 1'b1;
        end
        if (done_m) begin
            done_m = 1'b0;
            busy_m = 1'b0;
        end else if (busy_m) begin
            if (lat_m == 0) begin
                a = int'(a_m[11:0]);
                rdata_m = 32'h0;
                if (we_m) begin
                    mem[a] = wd_m[7:0];
                    if (md_m[1:0] != 2'b00) mem[(a + 1) % 4096] = wd_m[15:8];
                    if (md_m[1:0] == 2'b10) begin
                        mem[(a + 2) % 4096] = wd_m[23:16];
                        mem[(a + 3) % 4096] = wd_m[31:24];
                    end
                end else begin
                    case (md_m)
                        3'b000: rdata_m = {{24{mem[a][7]}}, mem[a]};
                        3'b100: rdata_m = {24'h0, mem[a]};
                        3'b001: rdata_m = {{16{mem[(a + 1) % 4096][7]}}, mem[(a + 1) % 4096], mem[a]};
                        3'b101: rdata_m = {16'h0, mem[(a + 1) % 4096], mem[a]};
                        default: rdata_m = {mem[(a + 3) % 4096], mem[(a + 2) % 4096],
                                            mem[(a + 1) % 4096], mem[a]};
                    endcase
                end
                done_m = 1'b1;
                n_done++;
            end else begin
                lat_m--;
            end
        end
        if (hang_release) hang_busy_m = 1'b0;
        if (mem_start) begin
            if (hang) begin
                hang_busy_m = 1'b1;
            end else begin
                busy_m = 1'b1;
                lat_m  = int'($urandom_range(0, 3));
                a_m    = mem_address;
                md_m   = mem_mode;
                we_m   = mem_write_enable;
                wd_m   = mem_write_data;
            end
        end
    end

    task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] base,
                          input logic [11:0] imm, input logic [31:0] sdata, input logic [4:0] rd,
                          input int kind, input logic [31:0] exp_data, input logic [1:0] exp_code);
        exp_t        e;
        logic [31:0] ea;
        int          k, cnt, s_wb, s_st, s_err, s_start, s_done;
        bit          want_start;
        ea = base + {{20{imm[11]}}, imm};
        e = '{kind: kind, rd: rd, data: exp_data, code: exp_code, addr: ea, mode: f3, we: st,
              wdata: sdata};
        want_start = !(kind == 2 && exp_code != 2'b11);
        @(negedge clk); #1;
        k = 0;
        while (!req_ready && k < 100) begin @(negedge clk); #1; k++; end
        check("ready_before_req", 32'(req_ready), 32'd1);
        if (!req_ready) return;
        s_wb = n_wb; s_st = n_store; s_err = n_err; s_start = n_start; s_done = n_done;
        q.push_back(e);
        req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_base = base;
        req_imm = imm; req_store_data = sdata; req_rd = rd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (k = 1; k <= 6; k++) begin
            @(negedge clk); #1;
            if (mem_start) break;
        end
        if (want_start) begin
            check("start_latency", 32'(k), 32'd2);
            @(negedge clk); #1;
            check("start_one_cycle", 32'(mem_start), 32'd0);
            if (kind == 2) begin
                cnt = 1;
                while (!err_valid && cnt < int'(T) + 10) begin @(negedge clk); #1; cnt++; end
                check("timeout_latency", 32'(cnt), 32'(T));
            end
        end else begin
            check("no_start_on_err", 32'(n_start - s_start), 32'd0);
        end
        if (kind == 3) begin
            k = 0;
            while (n_done == s_done && k < 100) begin @(negedge clk); #1; k++; end
            repeat (3) begin @(negedge clk); #1; end
            check("rd0_no_wb", 32'(n_wb - s_wb), 32'd0);
            if (q.size() > 0) e = q.pop_front();
        end else begin
            k = 0;
            while (q.size() != 0 && k < 100) begin @(negedge clk); #1; k++; end
            check("resp_seen", 32'(q.size()), 32'd0);
        end
        check("one_resp", 32'((n_wb - s_wb) + (n_store - s_st) + (n_err - s_err)),
              (kind == 3) ? 32'd0 : 32'd1);
        if (hang) begin
            hang = 1'b0;
            hang_release = 1'b1;
            @(negedge clk); #1;
            hang_release = 1'b0;
        end
        k = 0;
        while (!req_ready && k < 100) begin @(negedge clk); #1; k++; end
        check("ready_after_req", 32'(req_ready), 32'd1);
    endtask

    initial begin
        int k, s_wb, s_st, s_err;
        // Reset state
        #3;
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_ctrl", 32'({mem_start, mem_write_enable, wb_valid, store_done, err_valid,
                              err_code, mem_mode, wb_rd}), 32'd0);
        check("rst_addr", mem_address, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); #1;
        check("ready_after_reset", 32'(req_ready), 32'd1);

        do_req(1'b0, 3'b010, 32'h100, 12'h004, 32'h0, 5'd5, 0, 32'h1234_5678, 2'b00);
        do_req(1'b0, 3'b000, 32'h020, 12'h000, 32'h0, 5'd6, 0, 32'hFFFF_FF80, 2'b00);
        do_req(1'b0, 3'b100, 32'h010, 12'h010, 32'h0, 5'd7, 0, 32'h0000_0080, 2'b00);
        do_req(1'b0, 3'b001, 32'h030, 12'h000, 32'h0, 5'd8, 0, 32'hFFFF_9000, 2'b00);
        do_req(1'b0, 3'b101, 32'h034, 12'hFFC, 32'h0, 5'd9, 0, 32'h0000_9000, 2'b00);
        do_req(1'b1, 3'b010, 32'h200, 12'hFFC, 32'hDEAD_BEEF, 5'd0, 1, 32'h0, 2'b00);
        do_req(1'b0, 3'b010, 32'h1FC, 12'h000, 32'h0, 5'd10, 0, 32'hDEAD_BEEF, 2'b00);
        do_req(1'b1, 3'b000, 32'h300, 12'h000, 32'h1234_56AB, 5'd0, 1, 32'h0, 2'b00);
        do_req(1'b0, 3'b100, 32'h300, 12'h000, 32'h0, 5'd11, 0, 32'h0000_00AB, 2'b00);
        // Illegal funct3: load 011, store 100
        do_req(1'b0, 3'b011, 32'h040, 12'h000, 32'h0, 5'd12, 2, 32'h0, 2'b01);
        do_req(1'b1, 3'b100, 32'h050, 12'h7FF, 32'h0, 5'd0, 2, 32'h0, 2'b01);
        // Load to x0 completes silently
        do_req(1'b0, 3'b010, 32'h100, 12'h004, 32'h0, 5'd0, 3, 32'h0, 2'b00);
`ifdef MISALIGN_TRAP_EN
        do_req(1'b0, 3'b001, 32'h100, 12'h001, 32'h0, 5'd13, 2, 32'h0, 2'b10);
        do_req(1'b0, 3'b010, 32'h0FF, 12'h002, 32'h0, 5'd14, 2, 32'h0, 2'b10);
`else
        do_req(1'b0, 3'b001, 32'h100, 12'h001, 32'h0, 5'd13, 0, 32'h0000_3322, 2'b00);
        do_req(1'b0, 3'b010, 32'h0FF, 12'h002, 32'h0, 5'd14, 0, 32'h7844_3322, 2'b00);
`endif

        // Stray done while idle is ignored
        @(negedge clk); #1;
        s_wb = n_wb; s_st = n_store; s_err = n_err;
        stray_done = 1'b1;
        @(negedge clk); #1;
        stray_done = 1'b0;
        repeat (3) begin @(negedge clk); #1; end
        check("stray_done_ignored", 32'((n_wb - s_wb) + (n_store - s_st) + (n_err - s_err)), 32'd0);

        // Timeout against a controller that never finishes, then a normal request
        hang = 1'b1;
        do_req(1'b0, 3'b010, 32'h104, 12'h000, 32'h0, 5'd15, 2, 32'h0, 2'b11);
        do_req(1'b0, 3'b010, 32'h104, 12'h000, 32'h0, 5'd16, 0, 32'h1234_5678, 2'b00);

        // Reset during WAIT with the controller still busy
        hang = 1'b1;
        @(negedge clk); #1;
        req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b010; req_base = 32'h104;
        req_imm = 12'h000; req_rd = 5'd17;
        @(posedge clk); #1;
        req_valid = 1'b0;
        k = 0;
        while (!mem_start && k < 10) begin @(negedge clk); #1; k++; end
        check("midrst_started", 32'(mem_start), 32'd1);
        repeat (3) @(negedge clk);
        s_wb = n_wb; s_st = n_store; s_err = n_err;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_ready", 32'(req_ready), 32'd0);
        check("midrst_ctrl", 32'({mem_start, mem_write_enable, wb_valid, store_done, err_valid,
                                 err_code, mem_mode, wb_rd}), 32'd0);
        check("midrst_addr", mem_address, 32'd0);
        check("midrst_wb_data", wb_data, 32'd0);
        check("midrst_err_addr", err_addr, 32'd0);
        check("midrst_wdata", mem_write_data, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        hang = 1'b0;
        repeat (4) begin
            @(negedge clk); #1;
            check("ready_low_while_active", 32'(req_ready), 32'd0);
        end
        hang_release = 1'b1;
        @(negedge clk); #1;
        hang_release = 1'b0;
        check("active_fell", 32'(mem_active), 32'd0);
        check("ready_same_cycle", 32'(req_ready), 32'd0);
        @(negedge clk); #1;
        check("ready_rises_next", 32'(req_ready), 32'd1);
        repeat (3) begin @(negedge clk); #1; end
        check("midrst_no_strobes", 32'((n_wb - s_wb) + (n_store - s_st) + (n_err - s_err)), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_errors);
        $fatal(1);
    end

endmodule
